isr_priority_ctrl: RTL and testbench

ISR_PRIORITY_CTRL -- requirements
Module: isr_priority_ctrl

---
 rtl/isr_priority_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_isr_priority_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/isr_priority_ctrl.sv
// isr_priority_ctrl
// In-service / priority resolution block of an 8-level interrupt controller.
// It resolves the highest pending request against the highest in-service
// level under a rotating priority scheme. It runs the two-pulse INTA
// acknowledge sequence and decodes OCW2 EOI/rotation commands.
//
// Ports
//   clk           single clock, all state changes on its rising edge
//   reset         synchronous active-high reset
//   irr_masked    pending requests already masked by IMR
//   ocw2_wr       one-cycle strobe qualifying ocw2_data
//   ocw2_data     [7:5] = R,SL,EOI ; [2:0] = L
//   aeoi_mode     automatic EOI enabled
//   inta_pulse    one-cycle strobe per CPU INTA pulse
//   rotate        current lowest-priority level (7 = no rotation)
//   isr           in-service register
//   int_req       registered interrupt request to the CPU
//   irr_clear     one-hot, one-cycle pulse clearing the acknowledged IRR bit
//   vector_level  acknowledged level, qualified by vector_valid
//   vector_valid  one-cycle strobe on the second INTA pulse
module isr_priority_ctrl #(
  parameter logic [2:0] SPURIOUS_LEVEL = 3'd7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] irr_masked,
  input  logic       ocw2_wr,
  input  logic [7:0] ocw2_data,
  input  logic       aeoi_mode,
  input  logic       inta_pulse,
  output logic [2:0] rotate,
  output logic [7:0] isr,
  output logic       int_req,
  output logic [7:0] irr_clear,
  output logic [2:0] vector_level,
  output logic       vector_valid
);

  typedef enum logic [0:0] {IDLE = 1'b0, ACK1 = 1'b1} state_t;

  state_t     state_r, state_next_s;
  logic       auto_rot_r, auto_next_s;
  logic [2:0] level_r, level_next_s;
  logic       level_valid_r, level_valid_next_s;
  logic [2:0] rot_next_s;
  logic [7:0] isr_set_s, isr_clr_s, isr_next_s;
  logic [7:0] irr_clear_next_s;
  logic [2:0] vec_level_next_s;
  logic       vec_valid_next_s;
  logic       int_req_next_s;
  logic [3:0] pend_s, hisr_s;
  logic [2:0] pend_rank_s, hisr_rank_s;
  logic       preempt_s;

  // Returns {found, level} of the lowest-rank set bit; rank 0 sits just above rot.
  // Scanning from rank 7 down lets the lowest rank overwrite the result last.
  function automatic logic [3:0] find_highest(input logic [7:0] vec, input logic [2:0] rot);
    logic [3:0] res;
    logic [2:0] lvl;
    res = 4'd0;
    for (int k = 7; k >= 0; k--) begin
      lvl = rot + 3'd1 + 3'(k);
      if (vec[lvl]) begin
        res = {1'b1, lvl};
      end
    end
    return res;
  endfunction

  // Priority resolution on registered state plus the pending requests.
  always_comb begin
    pend_s      = find_highest(irr_masked, rotate);
    hisr_s      = find_highest(isr, rotate);
    pend_rank_s = pend_s[2:0] - rotate - 3'd1;
    hisr_rank_s = hisr_s[2:0] - rotate - 3'd1;
    preempt_s   = pend_s[3] && (!hisr_s[3] || (pend_rank_s < hisr_rank_s));
  end

  // Acknowledge FSM, OCW2 decode and next values of all registered outputs.
  always_comb begin
    state_next_s       = state_r;
    auto_next_s        = auto_rot_r;
    level_next_s       = level_r;
    level_valid_next_s = level_valid_r;
    rot_next_s         = rotate;
    isr_set_s          = 8'h00;
    isr_clr_s          = 8'h00;
    irr_clear_next_s   = 8'h00;
    vec_level_next_s   = vector_level;
    vec_valid_next_s   = 1'b0;
    int_req_next_s     = 1'b0;

    case (state_r)
      IDLE: begin
        if (inta_pulse) begin
          state_next_s       = ACK1;
          level_valid_next_s = pend_s[3];
          if (pend_s[3]) begin
            level_next_s                  = pend_s[2:0];
            isr_set_s[pend_s[2:0]]        = 1'b1;
            irr_clear_next_s[pend_s[2:0]] = 1'b1;
          end else begin
            level_next_s = SPURIOUS_LEVEL;
          end
        end else begin
          int_req_next_s = preempt_s;
        end
      end
      ACK1: begin
        if (inta_pulse) begin
          state_next_s     = IDLE;
          vec_valid_next_s = 1'b1;
          vec_level_next_s = level_r;
          // A spurious acknowledge never touches isr or rotate.
          if (aeoi_mode && level_valid_r) begin
            isr_clr_s[level_r] = 1'b1;
            if (auto_rot_r) begin
              rot_next_s = level_r;
            end else begin
              rot_next_s = rotate;
            end
          end else begin
            isr_clr_s = 8'h00;
          end
        end else begin
          state_next_s = ACK1;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase

    // OCW2 is decoded after the AEOI path so its rotate update wins.
    if (ocw2_wr) begin
      case (ocw2_data[7:5])
        3'b001: begin
          if (hisr_s[3]) begin
            isr_clr_s[hisr_s[2:0]] = 1'b1;
          end else begin
            isr_clr_s = isr_clr_s;
          end
        end
        3'b011: isr_clr_s[ocw2_data[2:0]] = 1'b1;
        3'b101: begin
          if (hisr_s[3]) begin
            isr_clr_s[hisr_s[2:0]] = 1'b1;
            rot_next_s             = hisr_s[2:0];
          end else begin
            isr_clr_s = isr_clr_s;
          end
        end
        3'b111: begin
          isr_clr_s[ocw2_data[2:0]] = 1'b1;
          rot_next_s                = ocw2_data[2:0];
        end
        3'b110:  rot_next_s  = ocw2_data[2:0];
        3'b100:  auto_next_s = 1'b1;
        3'b000:  auto_next_s = 1'b0;
        default: auto_next_s = auto_rot_r;
      endcase
    end else begin
      auto_next_s = auto_rot_r;
    end

    // Set wins over clear on the same bit; both derive from the pre-edge isr.
    isr_next_s = (isr & ~isr_clr_s) | isr_set_s;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      isr           <= 8'h00;
      rotate        <= 3'd7;
      auto_rot_r    <= 1'b0;
      level_r       <= 3'd0;
      level_valid_r <= 1'b0;
      int_req       <= 1'b0;
      irr_clear     <= 8'h00;
      vector_valid  <= 1'b0;
      vector_level  <= 3'd0;
    end else begin
      state_r       <= state_next_s;
      isr           <= isr_next_s;
      rotate        <= rot_next_s;
      auto_rot_r    <= auto_next_s;
      level_r       <= level_next_s;
      level_valid_r <= level_valid_next_s;
      int_req       <= int_req_next_s;
      irr_clear     <= irr_clear_next_s;
      vector_valid  <= vec_valid_next_s;
      vector_level  <= vec_level_next_s;
    end
  end

endmodule

// File: tb/tb_isr_priority_ctrl.sv
// tb_isr_priority_ctrl
// Directed bench for isr_priority_ctrl. A rank-based reference model built
// from the priority rules runs alongside the DUT and is compared on every
// falling edge; literal expectations pin the model on known scenarios.
module tb_isr_priority_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] irr_masked = 8'h00;
  logic       ocw2_wr = 1'b0;
  logic [7:0] ocw2_data = 8'h00;
  logic       aeoi_mode = 1'b0;
  logic       inta_pulse = 1'b0;
  logic [2:0] rotate;
  logic [7:0] isr;
  logic       int_req;
  logic [7:0] irr_clear;
  logic [2:0] vector_level;
  logic       vector_valid;

  int vectors = 0;
  int miscompares = 0;
  logic chk_en = 1'b0;

  isr_priority_ctrl #(.SPURIOUS_LEVEL(3'd7)) dut (
    .clk(clk), .reset(reset), .irr_masked(irr_masked), .ocw2_wr(ocw2_wr),
    .ocw2_data(ocw2_data), .aeoi_mode(aeoi_mode), .inta_pulse(inta_pulse),
    .rotate(rotate), .isr(isr), .int_req(int_req), .irr_clear(irr_clear),
    .vector_level(vector_level), .vector_valid(vector_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] isr;
    logic [2:0] rot;
    logic       auto_rot;
    logic       in_ack;
    logic [2:0] p;
    logic       p_real;
    logic       intr;
    logic [7:0] clr;
    logic       vv;
    logic [2:0] vl;
  } mstate_t;

  mstate_t m;

  function automatic int rank_of(input int lvl, input int rot);
    return (((lvl - rot - 1) % 8) + 8) % 8;
  endfunction

  // Level with smallest rank among set bits, or -1 when none is set.
  function automatic int best_of(input logic [7:0] vec, input int rot);
    int best;
    best = -1;
    for (int i = 0; i < 8; i++) begin
      if (vec[i] && (best < 0 || rank_of(i, rot) < rank_of(best, rot))) best = i;
    end
    return best;
  endfunction

  function automatic mstate_t model_next(input mstate_t s, input logic rst,
      input logic [7:0] irr, input logic wr, input logic [7:0] d,
      input logic aeoi, input logic inta);
    mstate_t n;
    int p, h, l;
    logic [7:0] clr, set;
    n = s;
    n.clr = 8'h00;
    n.vv = 1'b0;
    clr = 8'h00;
    set = 8'h00;
    if (rst) begin
      n = '0;
      n.rot = 3'd7;
      return n;
    end
    p = best_of(irr, int'(s.rot));
    h = best_of(s.isr, int'(s.rot));
    l = int'(d[2:0]);
    n.intr = !s.in_ack && !inta && (p >= 0) &&
             ((h < 0) || (rank_of(p, int'(s.rot)) < rank_of(h, int'(s.rot))));
    if (inta && !s.in_ack) begin
      n.in_ack = 1'b1;
      n.p_real = (p >= 0);
      n.p = (p >= 0) ? 3'(p) : 3'd7;
      if (p >= 0) begin
        set[p] = 1'b1;
        n.clr[p] = 1'b1;
      end
    end else if (inta && s.in_ack) begin
      n.in_ack = 1'b0;
      n.vv = 1'b1;
      n.vl = s.p;
      if (aeoi && s.p_real) begin
        clr[s.p] = 1'b1;
        if (s.auto_rot) n.rot = s.p;
      end
    end
    if (wr) begin
      case (d[7:5])
        3'd1: if (h >= 0) clr[h] = 1'b1;
        3'd3: clr[l] = 1'b1;
        3'd5: if (h >= 0) begin clr[h] = 1'b1; n.rot = 3'(h); end
        3'd7: begin clr[l] = 1'b1; n.rot = 3'(l); end
        3'd6: n.rot = 3'(l);
        3'd4: n.auto_rot = 1'b1;
        3'd0: n.auto_rot = 1'b0;
        default: ;
      endcase
    end
    n.isr = (s.isr & ~clr) | set;
    return n;
  endfunction

  always @(posedge clk) begin
    m <= model_next(m, reset, irr_masked, ocw2_wr, ocw2_data, aeoi_mode, inta_pulse);
  end

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model comparison on every falling edge once reset has been applied.
  always @(negedge clk) begin
    if (chk_en) begin
      check8("model.isr", isr, m.isr);
      check8("model.rotate", {5'd0, rotate}, {5'd0, m.rot});
      check8("model.int_req", {7'd0, int_req}, {7'd0, m.intr});
      check8("model.irr_clear", irr_clear, m.clr);
      check8("model.vector_valid", {7'd0, vector_valid}, {7'd0, m.vv});
      check8("model.vector_level", {5'd0, vector_level}, {5'd0, m.vl});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ocw2(input logic [7:0] d);
    ocw2_wr = 1'b1;
    ocw2_data = d;
    tick();
    ocw2_wr = 1'b0;
  endtask

  task automatic inta();
    inta_pulse = 1'b1;
    tick();
    inta_pulse = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    check8("rst.isr", isr, 8'h00);
    check8("rst.rotate", {5'd0, rotate}, 8'd7);
    check8("rst.int_req", {7'd0, int_req}, 8'd0);
    check8("rst.vv", {7'd0, vector_valid}, 8'd0);
    check8("rst.vl", {5'd0, vector_level}, 8'd0);

    // Basic acknowledge of IR3 out of {3,5}
    irr_masked = 8'h28;
    tick();
    check8("ack.int_req", {7'd0, int_req}, 8'd1);
    inta();
    check8("ack1.isr", isr, 8'h08);
    check8("ack1.irr_clear", irr_clear, 8'h08);
    check8("ack1.int_req", {7'd0, int_req}, 8'd0);
    irr_masked = 8'h20;
    inta();
    check8("ack2.vl", {5'd0, vector_level}, 8'd3);
    check8("ack2.vv", {7'd0, vector_valid}, 8'd1);

    // Preemption only by a higher-ranked request
    tick();
    check8("nest.lower", {7'd0, int_req}, 8'd0);
    irr_masked = 8'h02;
    tick();
    check8("nest.higher", {7'd0, int_req}, 8'd1);

    // Rotate on non-specific EOI
    irr_masked = 8'h00;
    ocw2(8'hA0);
    check8("rot.isr", isr, 8'h00);
    check8("rot.rotate", {5'd0, rotate}, 8'd3);
    irr_masked = 8'h09;
    tick();
    inta();
    check8("rot.ack09.isr", isr, 8'h01);
    irr_masked = 8'h08;
    inta();
    check8("rot.ack09.vl", {5'd0, vector_level}, 8'd0);
    ocw2(8'h20);
    irr_masked = 8'h18;
    tick();
    inta();
    irr_masked = 8'h08;
    inta();
    check8("rot.ack18.vl", {5'd0, vector_level}, 8'd4);
    ocw2(8'h20);
    check8("rot.eoi.isr", isr, 8'h00);

    // AEOI with auto-rotate
    ocw2(8'h80);
    aeoi_mode = 1'b1;
    irr_masked = 8'h20;
    tick();
    inta();
    check8("aeoi.isr1", isr, 8'h20);
    irr_masked = 8'h00;
    inta();
    check8("aeoi.isr2", isr, 8'h00);
    check8("aeoi.rotate", {5'd0, rotate}, 8'd5);
    check8("aeoi.vl", {5'd0, vector_level}, 8'd5);
    aeoi_mode = 1'b0;
    ocw2(8'h00);

    // Spurious acknowledge and EOI with empty isr
    inta();
    check8("spur.isr", isr, 8'h00);
    check8("spur.irr_clear", irr_clear, 8'h00);
    inta();
    check8("spur.vl", {5'd0, vector_level}, 8'd7);
    check8("spur.vv", {7'd0, vector_valid}, 8'd1);
    ocw2(8'h20);
    check8("eoi0.isr", isr, 8'h00);
    check8("eoi0.rotate", {5'd0, rotate}, 8'd5);

    // Reset during ACK1
    irr_masked = 8'h02;
    tick();
    inta();
    check8("rack.isr", isr, 8'h02);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check8("rack.rst.isr", isr, 8'h00);
    check8("rack.rst.rotate", {5'd0, rotate}, 8'd7);
    check8("rack.rst.vv", {7'd0, vector_valid}, 8'd0);
    irr_masked = 8'h04;
    inta();
    check8("rack.first.isr", isr, 8'h04);
    check8("rack.first.irr_clear", irr_clear, 8'h04);
    irr_masked = 8'h00;
    inta();
    check8("rack.second.vl", {5'd0, vector_level}, 8'd2);

    // Same-cycle OCW2 and INTA
    ocw2(8'h80);
    irr_masked = 8'h01;
    tick();
    ocw2_wr = 1'b1;
    ocw2_data = 8'h20;
    inta();
    ocw2_wr = 1'b0;
    check8("same.isr", isr, 8'h01);
    irr_masked = 8'h00;
    aeoi_mode = 1'b1;
    ocw2_wr = 1'b1;
    ocw2_data = 8'hC2;
    inta();
    ocw2_wr = 1'b0;
    aeoi_mode = 1'b0;
    check8("same.aeoi.isr", isr, 8'h00);
    check8("same.rotate", {5'd0, rotate}, 8'd2);
    irr_masked = 8'h08;
    ocw2_wr = 1'b1;
    ocw2_data = 8'h63;
    inta();
    ocw2_wr = 1'b0;
    check8("setwins.isr", isr, 8'h08);
    irr_masked = 8'h00;
    inta();

    // Mixed traffic cross-checked against the model
    for (int i = 0; i < 200; i++) begin
      irr_masked = 8'($urandom);
      ocw2_wr    = ($urandom_range(0, 3) == 0);
      ocw2_data  = 8'($urandom);
      aeoi_mode  = 1'($urandom_range(0, 1));
      inta_pulse = ($urandom_range(0, 2) == 0);
      tick();
    end
    inta_pulse = 1'b0;
    ocw2_wr = 1'b0;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
